// File: rtl/mem_arb_pkg.sv
// Shared types for the data memory arbiter: FSM states, access sizes and
// the bank-select encoding of byte address bit 0.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef enum logic {
    SIZE_BYTE = 1'b0,
    SIZE_HALF = 1'b1
  } acc_size_t;

  localparam logic BANK_EVEN = 1'b0;
  localparam logic BANK_ODD  = 1'b1;

endpackage

// File: rtl/mem_bank_mapper.sv
// Combinational splitter from one byte-addressed access onto the even/odd
// byte banks, including the merged read data.
module mem_bank_mapper
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int BANK_AW = 8
) (
  input  logic [ADDR_W-1:0]  addr,
  input  acc_size_t          size,
  input  logic               we,
  input  logic [15:0]        wdata,
  input  logic [7:0]         even_rdata,
  input  logic [7:0]         odd_rdata,
  output logic [BANK_AW-1:0] even_addr,
  output logic [BANK_AW-1:0] odd_addr,
  output logic               even_we,
  output logic               odd_we,
  output logic [7:0]         even_wdata,
  output logic [7:0]         odd_wdata,
  output logic [15:0]        rdata
);

  logic [BANK_AW-1:0] row;
  logic               lane;

  assign row  = addr[ADDR_W-1:1];
  assign lane = addr[0];

  always_comb begin
    even_addr  = row;
    odd_addr   = row;
    even_we    = 1'b0;
    odd_we     = 1'b0;
    even_wdata = wdata[7:0];
    odd_wdata  = wdata[7:0];
    rdata      = '0;
    if (size == SIZE_BYTE) begin
      if (lane == BANK_EVEN) begin
        even_we = we;
        rdata   = {8'h00, even_rdata};
      end else begin
        odd_we = we;
        rdata  = {8'h00, odd_rdata};
      end
    end else begin
      even_we = we;
      odd_we  = we;
      if (lane == BANK_ODD) begin
        // Misaligned halfword: high byte spills into the next even row, wrapping.
        even_addr  = row + 1'b1;
        even_wdata = wdata[15:8];
        rdata      = {even_rdata, odd_rdata};
      end else begin
        odd_wdata = wdata[15:8];
        rdata     = {odd_rdata, even_rdata};
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the even/odd data banks between the core MEM stage and a burst
// DMA port: core priority when idle, alternation during bursts, starvation guard.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int BANK_AW      = 8,
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               core_req,
  input  logic               core_we,
  input  logic               core_byte,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [15:0]        core_wdata,
  output logic [15:0]        core_rdata,
  output logic               core_stall,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [ADDR_W-1:0]  dma_addr,
  input  logic [LEN_W-1:0]   dma_len,
  output logic               dma_ack,
  input  logic [15:0]        dma_wdata,
  output logic               dma_wready,
  output logic [15:0]        dma_rdata,
  output logic               dma_rvalid,
  output logic               dma_done,
  output logic [BANK_AW-1:0] even_addr,
  output logic [BANK_AW-1:0] odd_addr,
  output logic               even_we,
  output logic               odd_we,
  output logic [7:0]         even_wdata,
  output logic [7:0]         odd_wdata,
  input  logic [7:0]         even_rdata,
  input  logic [7:0]         odd_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic               last_dma_reg, last_dma_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;
  logic [ADDR_W-1:0]  cur_addr_reg, cur_addr_next;
  logic               burst_we_reg, burst_we_next;
  logic               core_served, beat, accept, done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      last_dma_reg   <= 1'b0;
      remaining_reg  <= '0;
      cur_addr_reg   <= '0;
      burst_we_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      last_dma_reg   <= last_dma_next;
      remaining_reg  <= remaining_next;
      cur_addr_reg   <= cur_addr_next;
      burst_we_reg   <= burst_we_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    last_dma_next   = last_dma_reg;
    remaining_next  = remaining_reg;
    cur_addr_next   = cur_addr_reg;
    burst_we_next   = burst_we_reg;
    core_served     = 1'b0;
    beat            = 1'b0;
    accept          = 1'b0;
    done            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dma_req && (!core_req || starve_cnt_reg == CNT_W'(STARVE_LIMIT))) begin
          accept          = 1'b1;
          state_next      = BURST;
          cur_addr_next   = dma_addr;
          remaining_next  = (dma_len == '0) ? LEN_W'(1) : dma_len;
          burst_we_next   = dma_we;
          last_dma_next   = 1'b0;
          starve_cnt_next = '0;
        end else begin
          core_served     = core_req;
          starve_cnt_next = (dma_req && core_req) ? starve_cnt_reg + 1'b1 : '0;
        end
      end
      BURST: begin
        // Core may only cut in right after a DMA beat, so its stall is one cycle max.
        if (core_req && last_dma_reg) begin
          core_served   = 1'b1;
          last_dma_next = 1'b0;
        end else begin
          beat           = 1'b1;
          last_dma_next  = 1'b1;
          cur_addr_next  = cur_addr_reg + ADDR_W'(2);
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_W'(1)) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [ADDR_W-1:0]  map_addr;
  acc_size_t          map_size;
  logic               map_we;
  logic [15:0]        map_wdata, map_rdata;
  logic [BANK_AW-1:0] map_even_addr, map_odd_addr;
  logic               map_even_we, map_odd_we;
  logic [7:0]         map_even_wdata, map_odd_wdata;
  logic               live;

  assign live      = ~reset;
  assign map_addr  = beat ? cur_addr_reg : core_addr;
  assign map_size  = (beat || !core_byte) ? SIZE_HALF : SIZE_BYTE;
  assign map_we    = (beat & burst_we_reg) | (core_served & core_we);
  assign map_wdata = beat ? dma_wdata : core_wdata;

  mem_bank_mapper #(
    .ADDR_W  (ADDR_W),
    .BANK_AW (BANK_AW)
  ) u_mapper (
    .addr       (map_addr),
    .size       (map_size),
    .we         (map_we),
    .wdata      (map_wdata),
    .even_rdata (even_rdata),
    .odd_rdata  (odd_rdata),
    .even_addr  (map_even_addr),
    .odd_addr   (map_odd_addr),
    .even_we    (map_even_we),
    .odd_we     (map_odd_we),
    .even_wdata (map_even_wdata),
    .odd_wdata  (map_odd_wdata),
    .rdata      (map_rdata)
  );

  // Every output is forced quiet while reset is high, including bank writes.
  assign core_rdata = (live && core_served) ? map_rdata : '0;
  assign core_stall = live & core_req & ~core_served;
  assign dma_ack    = live & accept;
  assign dma_wready = live & beat & burst_we_reg;
  assign dma_rvalid = live & beat & ~burst_we_reg;
  assign dma_rdata  = (live && beat && !burst_we_reg) ? map_rdata : '0;
  assign dma_done   = live & done;
  assign even_addr  = live ? map_even_addr : '0;
  assign odd_addr   = live ? map_odd_addr : '0;
  assign even_we    = live & map_even_we;
  assign odd_we     = live & map_odd_we;
  assign even_wdata = live ? map_even_wdata : '0;
  assign odd_wdata  = live ? map_odd_wdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: random and directed traffic against a flat byte-memory
// reference model with a transaction-level view of the arbitration rules.
module tb_data_mem_arbiter;

  localparam int ADDR_W       = 9;
  localparam int BANK_AW      = 8;
  localparam int LEN_W        = 8;
  localparam int STARVE_LIMIT = 8;
  localparam int MEM_BYTES    = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               core_req, core_we, core_byte;
  logic [ADDR_W-1:0]  core_addr;
  logic [15:0]        core_wdata, core_rdata;
  logic               core_stall;
  logic               dma_req, dma_we;
  logic [ADDR_W-1:0]  dma_addr;
  logic [LEN_W-1:0]   dma_len;
  logic               dma_ack, dma_wready, dma_rvalid, dma_done;
  logic [15:0]        dma_wdata, dma_rdata;
  logic [BANK_AW-1:0] even_addr, odd_addr;
  logic               even_we, odd_we;
  logic [7:0]         even_wdata, odd_wdata, even_rdata, odd_rdata;

  data_mem_arbiter #(
    .ADDR_W(ADDR_W), .BANK_AW(BANK_AW), .LEN_W(LEN_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_byte(core_byte),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_ack(dma_ack), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .even_addr(even_addr), .odd_addr(odd_addr), .even_we(even_we), .odd_we(odd_we),
    .even_wdata(even_wdata), .odd_wdata(odd_wdata),
    .even_rdata(even_rdata), .odd_rdata(odd_rdata)
  );

  // Bank storage: combinational read, write at the clock edge.
  logic [7:0] even_mem [256];
  logic [7:0] odd_mem  [256];
  assign even_rdata = even_mem[even_addr];
  assign odd_rdata  = odd_mem[odd_addr];
  always @(posedge clk) begin
    if (even_we) even_mem[even_addr] <= even_wdata;
    if (odd_we)  odd_mem[odd_addr]   <= odd_wdata;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: flat byte memory plus burst bookkeeping.
  logic [7:0] ref_mem [MEM_BYTES];
  bit m_busy = 0;
  int m_left = 0, m_addr = 0, m_wait = 0;
  bit m_we = 0, m_prev_beat = 0;

  int stall_run = 0, max_stall_run = 0;
  logic               snap_ack;
  logic [BANK_AW-1:0] snap_even_addr, snap_odd_addr;

  function automatic logic [15:0] ref_half(input int a);
    return {ref_mem[(a + 1) % MEM_BYTES], ref_mem[a % MEM_BYTES]};
  endfunction

  task automatic drive(input bit creq, input bit cwe, input bit cbyte, input int caddr,
                       input int cwd, input bit dreq, input bit dwe, input int daddr,
                       input int dlen, input int dwd);
    core_req   = creq;
    core_we    = cwe;
    core_byte  = cbyte;
    core_addr  = ADDR_W'(caddr);
    core_wdata = 16'(cwd);
    dma_req    = dreq;
    dma_we     = dwe;
    dma_addr   = ADDR_W'(daddr);
    dma_len    = LEN_W'(dlen);
    dma_wdata  = 16'(dwd);
  endtask

  task automatic idle_drive();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: compare DUT outputs with the model at the falling edge, then advance.
  task automatic cycle();
    bit e_ack, e_stall, e_rv, e_wr, e_done, core_go, dma_go;
    int ca;
    @(negedge clk);
    snap_ack       = dma_ack;
    snap_even_addr = even_addr;
    snap_odd_addr  = odd_addr;
    if (reset) begin
      check_eq("reset_outs",
               {core_rdata, core_stall, dma_ack, dma_wready, dma_rdata, dma_rvalid, dma_done,
                even_addr, odd_addr, even_we, odd_we, even_wdata, odd_wdata}, '0);
      m_busy = 0; m_left = 0; m_addr = 0; m_wait = 0; m_we = 0; m_prev_beat = 0;
      stall_run = 0;
    end else begin
      e_ack = 0; e_rv = 0; e_wr = 0; e_done = 0; core_go = 0; dma_go = 0;
      if (!m_busy) begin
        if (dma_req && (!core_req || m_wait == STARVE_LIMIT)) begin
          e_ack = 1;
          m_busy = 1;
          m_addr = int'(dma_addr);
          m_left = (dma_len == 0) ? 1 : int'(dma_len);
          m_we = dma_we;
          m_prev_beat = 0;
          m_wait = 0;
          $display("[TB] t=%0t burst accepted addr=%03h len=%0d we=%0d core_req=%0d",
                   $time, dma_addr, m_left, dma_we, core_req);
        end else begin
          core_go = core_req;
          m_wait = (dma_req && core_req) ? m_wait + 1 : 0;
        end
      end else if (core_req && m_prev_beat) begin
        core_go = 1;
        m_prev_beat = 0;
      end else begin
        dma_go = 1;
        m_prev_beat = 1;
      end
      e_stall = core_req && !core_go;
      check_eq("core_stall", core_stall, e_stall);
      check_eq("dma_ack", dma_ack, e_ack);

      if (core_go) begin
        ca = int'(core_addr);
        if (!core_we) begin
          if (core_byte) check_eq("core_rdata_b", core_rdata, {8'h00, ref_mem[ca]});
          else           check_eq("core_rdata_h", core_rdata, ref_half(ca));
        end else begin
          ref_mem[ca] = core_wdata[7:0];
          if (!core_byte) ref_mem[(ca + 1) % MEM_BYTES] = core_wdata[15:8];
        end
      end
      if (dma_go) begin
        e_rv = !m_we;
        e_wr = m_we;
        if (!m_we) check_eq("dma_rdata", dma_rdata, ref_half(m_addr));
        else begin
          ref_mem[m_addr] = dma_wdata[7:0];
          ref_mem[(m_addr + 1) % MEM_BYTES] = dma_wdata[15:8];
        end
        m_addr = (m_addr + 2) % MEM_BYTES;
        m_left--;
        if (m_left == 0) begin
          e_done = 1;
          m_busy = 0;
        end
      end
      check_eq("dma_rvalid", dma_rvalid, e_rv);
      check_eq("dma_wready", dma_wready, e_wr);
      check_eq("dma_done", dma_done, e_done);
      if (!core_go && !dma_go) check_eq("bank_we_idle", {even_we, odd_we}, 2'b00);

      stall_run = core_stall ? stall_run + 1 : 0;
      if (stall_run > max_stall_run) max_stall_run = stall_run;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle_drive();
    repeat (n) cycle();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle_drive();
    repeat (3) cycle();
    reset = 1'b0;

    // Fill memory through the core so banks and model start identical.
    for (int i = 0; i < MEM_BYTES; i += 2) begin
      drive(1, 1, 0, i, $urandom_range(0, 16'hFFFF), 0, 0, 0, 0, 0);
      cycle();
    end

    // Misaligned halfword store/load at 0x005.
    drive(1, 1, 0, 'h005, 'hABCD, 0, 0, 0, 0, 0);
    cycle();
    check_eq("odd_bank_02", odd_mem[2], 8'hCD);
    check_eq("even_bank_03", even_mem[3], 8'hAB);
    drive(1, 0, 0, 'h005, 0, 0, 0, 0, 0, 0);
    cycle();

    // DMA read of 4 beats with the core idle.
    drive(0, 0, 0, 0, 0, 1, 0, 'h010, 4, 0);
    cycle();
    check_eq("dma_read_ack", snap_ack, 1'b1);
    idle_cycles(6);

    // Core held high through a 4-beat DMA write.
    drive(0, 0, 0, 0, 0, 1, 1, 'h040, 4, 0);
    cycle();
    max_stall_run = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, $urandom_range(0, 511), 0, 0, 1, 0, 0, $urandom_range(0, 16'hFFFF));
      cycle();
    end
    check_eq("stall_run_max1", max_stall_run <= 1, 1'b1);
    idle_cycles(2);

    // Starvation: both requesters held high from IDLE.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, $urandom_range(0, 511), 0, 1, 0, 'h080, 1, 0);
      cycle();
      if (snap_ack) break;
      n++;
    end
    check_eq("starve_wait", n, STARVE_LIMIT);
    idle_cycles(3);

    // Reset during beat 2 of a 5-beat write.
    drive(0, 0, 0, 0, 0, 1, 1, 'h100, 5, 'h1111);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h2222);
    cycle();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h3333);
    cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h4444);
    cycle();
    drive(1, 0, 0, 'h100, 0, 0, 0, 0, 0, 0);
    cycle();
    idle_cycles(2);

    // Wrap-around: halfword load at 0x1FF, then a 2-beat read burst from 0x1FE.
    drive(1, 0, 0, 'h1FF, 0, 0, 0, 0, 0, 0);
    cycle();
    check_eq("wrap_odd_addr", snap_odd_addr, 8'hFF);
    check_eq("wrap_even_addr", snap_even_addr, 8'h00);
    drive(0, 0, 0, 0, 0, 1, 0, 'h1FE, 2, 0);
    cycle();
    idle_drive();
    cycle();
    check_eq("burst_wrap_b1", {snap_even_addr, snap_odd_addr}, {8'hFF, 8'hFF});
    cycle();
    check_eq("burst_wrap_b2", {snap_even_addr, snap_odd_addr}, {8'h00, 8'h00});
    idle_cycles(2);

    // Random traffic: a balanced phase, then a core-heavy phase to exercise starvation.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 1500; i++) begin
        reset = ($urandom_range(0, 199) == 0);
        drive(phase == 0 ? $urandom_range(0, 1) : ($urandom_range(0, 9) != 0),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 511),
              $urandom_range(0, 16'hFFFF), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
              $urandom_range(0, 511), $urandom_range(0, 6), $urandom_range(0, 16'hFFFF));
        cycle();
      end
    end
    reset = 1'b0;
    idle_cycles(20);

    for (int i = 0; i < 256; i++) begin
      check_eq("mem_even", even_mem[i], ref_mem[2 * i]);
      check_eq("mem_odd", odd_mem[i], ref_mem[2 * i + 1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
